// File: rtl/hilo_mul_ctrl.sv
// HI/LO register pair with a radix-2 shift-add sequencer for MULTU.
// One multiplier bit is retired per cycle; a stall holds dependent reads until commit.
module hilo_mul_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   input  logic             rd_hi_req,
   input  logic             rd_lo_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      // acc never exceeds WIDTH bits between steps, so the WIDTH+1 sum holds the carry
      sum      = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = MUL;
            end
         end
         MUL: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               // shift {sum, mplier} right: carry lands in acc MSB, sum LSB enters mplier
               acc_d    = {1'b0, sum[WIDTH:1]};
               mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  hi_d    = acc_d[WIDTH-1:0];
                  lo_d    = mplier_d;
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state_q == MUL);
   assign done  = done_q;
   assign stall = busy & (rd_hi_req | rd_lo_req | start);

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl: latency, commit values, stall, back-to-back, abort and async reset.
module tb_hilo_mul_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a, b;
   logic          abort;
   logic          rd_hi_req, rd_lo_req;
   logic [W-1:0]  hi, lo;
   logic          busy, done, stall;

   int pass_cnt  = 0;
   int total_cnt = 0;

   hilo_mul_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .abort(abort),
      .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after a posedge with the unit idle (or in its done cycle).
   // mode: 0 no reads, 1 MFHI held, 2 MFLO held while busy.
   // Returns in the done cycle.
   task automatic run_mul(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int mode);
      logic [W-1:0] old_hi, old_lo;
      int cycles;
      bit hold_bad, stall_bad, done_bad;
      old_hi = hi;
      old_lo = lo;
      start = 1'b1; a = av; b = bv;
      #1;
      chk({name, "_stall_idle"}, W'(stall), W'(0));
      step();
      start = 1'b0; a = '0; b = '0;
      rd_hi_req = (mode == 1);
      rd_lo_req = (mode == 2);
      #1;
      cycles = 0; hold_bad = 0; stall_bad = 0; done_bad = 0;
      while (busy === 1'b1 && cycles < 100) begin
         if (hi !== old_hi || lo !== old_lo) hold_bad = 1;
         if (stall !== (mode != 0)) stall_bad = 1;
         if (done !== 1'b0) done_bad = 1;
         cycles++;
         @(posedge clk);
         #2;
      end
      chk({name, "_busy_cycles"}, W'(cycles), W'(32));
      chk({name, "_hilo_hold"}, W'(hold_bad), W'(0));
      chk({name, "_stall_busy"}, W'(stall_bad), W'(0));
      chk({name, "_no_early_done"}, W'(done_bad), W'(0));
      chk({name, "_done"}, W'(done), W'(1));
      chk({name, "_stall_done"}, W'(stall), W'(0));
      chk({name, "_hi"}, hi, exp_hi);
      chk({name, "_lo"}, lo, exp_lo);
      rd_hi_req = 1'b0;
      rd_lo_req = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; a = 32'h5; b = 32'h7; abort = 1'b0;
      rd_hi_req = 1'b1; rd_lo_req = 1'b1;
      repeat (2) step();
      chk("reset_hi", hi, '0);
      chk("reset_lo", lo, '0);
      chk("reset_busy", W'(busy), W'(0));
      chk("reset_done", W'(done), W'(0));
      chk("reset_stall", W'(stall), W'(0));
      start = 1'b0; rd_hi_req = 1'b0; rd_lo_req = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic;
      run_mul("mul3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F, 0);
      step();
      chk("mul3x5_done_once", W'(done), W'(0));
      run_mul("mulmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
      step();
   endtask

   task automatic test_zero_and_stall;
      run_mul("zero_b", 32'h12345678, 32'h0, 32'h0, 32'h0, 0);
      step();
      run_mul("zero_a", 32'h0, 32'h9ABCDEF0, 32'h0, 32'h0, 1);
      step();
      run_mul("lo_read", 32'h00000100, 32'h00000100, 32'h0, 32'h00010000, 2);
      step();
   endtask

   task automatic test_back_to_back;
      run_mul("mul7x6", 32'd7, 32'd6, 32'h0, 32'd42, 0);
      run_mul("b2b", 32'h00010000, 32'h00010000, 32'h00000001, 32'h0, 0);
      step();
      // restore hi=0, lo=42 for the abort scenario
      run_mul("mul7x6b", 32'd7, 32'd6, 32'h0, 32'd42, 0);
      step();
   endtask

   task automatic test_abort;
      bit done_seen;
      start = 1'b1; a = 32'd9; b = 32'd9;
      step();
      start = 1'b0;
      repeat (9) step();
      chk("abort_busy_before", W'(busy), W'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_done", W'(done), W'(0));
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) done_seen = 1;
         step();
      end
      chk("abort_no_done_later", W'(done_seen), W'(0));
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'd42);
      abort = 1'b1; start = 1'b1; a = 32'd2; b = 32'd2;
      step();
      abort = 1'b0; start = 1'b0;
      chk("abort_blocks_start", W'(busy), W'(0));
      step();
   endtask

   task automatic test_async_reset;
      start = 1'b1; a = 32'd9; b = 32'd9;
      step();
      start = 1'b0;
      repeat (5) step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_hi", hi, '0);
      chk("arst_lo", lo, '0);
      chk("arst_busy", W'(busy), W'(0));
      #1;
      rst = 1'b0;
      step();
      run_mul("post_rst", 32'd2, 32'd3, 32'h0, 32'd6, 0);
      step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; abort = 1'b0;
      rd_hi_req = 1'b0; rd_lo_req = 1'b0;
      test_reset();
      test_basic();
      test_zero_and_stall();
      test_back_to_back();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule

// File: doc/hilo_mul_ctrl.md
Name: hilo_mul_ctrl

Overview:
Iterative sequencer for the MULTU instruction. It owns the HI/LO register pair and runs a radix-2 shift-add unsigned multiply, one bit per cycle. The start strobe is the decoded HI/LO write-enable in EX. The block returns a stall to the hazard unit so that MFHI/MFLO, or a second MULTU, waits until the product is committed.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits, split into hi (upper) and lo (lower).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  MULTU in EX (hilo_we); sampled only in IDLE
a  in  WIDTH  multiplicand (rs value)
b  in  WIDTH  multiplier (rt value)
abort  in  1  pipeline flush; kills an in-flight multiply
rd_hi_req  in  1  MFHI in EX
rd_lo_req  in  1  MFLO in EX
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  multiply in progress
done  out  1  one-cycle pulse on the commit edge
stall  out  1  freeze request to the hazard unit

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=0; lo=0; busy=0; done=0; internal multiplicand, accumulator, multiplier and count all 0. Takes effect immediately, including mid-multiply; the partial product is discarded.
- States: IDLE, MUL.
- IDLE, start=1 at edge E0:
  - latch mcand=a, mplier=b; acc=0 (WIDTH+1 bits incl. carry); count=0.
  - go to MUL; busy=1 from E0 onward.
- MUL, each edge:
  - if mplier[0]=1: sum = acc + mcand, else sum = acc.
  - shift the {sum, mplier} concatenation right by 1, so the carry enters the acc MSB; count++.
- Commit edge, E_WIDTH (count reaches WIDTH-1 before the edge):
  - hi <= final upper WIDTH bits; lo <= final lower WIDTH bits.
  - state=IDLE, busy=0, done=1 for exactly one cycle.
- Latency:
  - new hi/lo visible after WIDTH edges following E0 (32 cycles at default).
  - a start accepted in the cycle where done=1 is legal (back-to-back).
- hi/lo hold their previous values throughout MUL; they are written only on the commit edge.
- stall = busy & (rd_hi_req | rd_lo_req | start). Combinational; 0 whenever busy=0.
- start while busy is ignored by the unit. stall holds it upstream until it is re-presented in IDLE.
- abort=1 in MUL: next state IDLE, busy=0, done=0, hi/lo unchanged.
- abort has priority over the commit edge and over start. In IDLE, abort with start=1 means the start is not accepted.
- Arithmetic is unsigned only; no overflow is possible, because the product fits in 2*WIDTH bits.
- The block does not write the register file. MFHI/MFLO read hi/lo directly once stall=0.

Test Plan:
- Reset, then start with a=3, b=5 -> busy=1 for 32 cycles; done pulses once; hi=0x00000000, lo=0x0000000F; stall=0 throughout, since no reads were issued.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> after commit hi=0xFFFFFFFE, lo=0x00000001 (exercises the carry path).
- a=0x12345678, b=0 and a=0, b=0x9ABCDEF0 -> hi=0, lo=0. Then rd_hi_req=1 held from the cycle after start -> stall=1 every cycle while busy and 0 in the done cycle.
- Multiply 7*6 (lo=42). Then in the done cycle start a=0x00010000, b=0x00010000 -> accepted; during busy lo stays 42 and hi stays 0; after commit hi=0x00000001, lo=0.
- With hi=0, lo=42, start 9*9 and pulse abort at cycle 10 -> busy=0 next cycle, no done pulse, hi=0, lo=42 retained.
- Start 9*9 then assert rst asynchronously mid-multiply (between clock edges) -> hi=0, lo=0, busy=0 immediately. After rst release, a start of 2*3 gives lo=6.
